// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// serial_tx_arbiter
//
// Round-robin arbiter that lets several packet producers share one serial TX packager. It sits
// between the requesters and the packager's data/ce/busy inputs. It issues single-cycle push
// strobes, never pushes while the packager reports busy, and limits every grant to MaxBurst
// consecutive packets so that one requester cannot starve the others.
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous reset, active low (0 = reset)
//   req       in   per-requester request, held high until acknowledged
//   data      in   packed packets, requester i at [i*PacketWidth +: PacketWidth]
//   ack       out  one-cycle pulse, packet of the flagged requester was accepted
//   grant_id  out  index of the currently granted requester
//   active    out  high while the arbiter is not idle
//   tx_ce     out  one-cycle push strobe to the packager
//   tx_data   out  packet to the packager, valid while tx_ce is high
//   tx_busy   in   packager queue full, no push is issued while high
//
// Every grant walks IDLE -> SEND -> PUSH (-> SEND -> PUSH ...) -> IDLE. A push is decided in
// SEND and becomes visible on tx_ce/ack during PUSH, so the sustained rate is one packet per
// two clocks and tx_busy seen in SEND already accounts for the previous push.
// ---------------------------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int unsigned IdWidth     = 2,
    parameter int unsigned PacketWidth = 32,
    parameter int unsigned MaxBurst    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [(2**IdWidth)-1:0]             req,
    input  logic [(2**IdWidth)*PacketWidth-1:0] data,
    output logic [(2**IdWidth)-1:0]             ack,
    output logic [IdWidth-1:0]                  grant_id,
    output logic                                active,
    output logic                                tx_ce,
    output logic [PacketWidth-1:0]              tx_data,
    input  logic                                tx_busy
);

    localparam int unsigned Requesters = 2 ** IdWidth;
    localparam int unsigned BurstWidth = $clog2(MaxBurst + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StPush
    } state_e;

    // -----------------------------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [IdWidth-1:0]      grant_q, grant_d;
    logic [IdWidth-1:0]      last_q, last_d;
    logic [BurstWidth-1:0]   burst_q, burst_d;
    logic [Requesters-1:0]   ack_q, ack_d;
    logic                    tx_ce_q, tx_ce_d;
    logic [PacketWidth-1:0]  tx_data_q, tx_data_d;
    logic                    active_q, active_d;

    // -----------------------------------------------------------------------------------------
    // Helper decodes
    // -----------------------------------------------------------------------------------------
    logic [PacketWidth-1:0]  data_arr [Requesters];
    logic [IdWidth-1:0]      pick_id;
    logic                    pick_valid;
    logic                    req_granted;
    logic                    burst_open;
    logic                    push;

    for (genvar gi = 0; gi < Requesters; gi++) begin : g_unpack
        assign data_arr[gi] = data[gi*PacketWidth +: PacketWidth];
    end

    // Search starts one past the last served requester; the IdWidth-bit add wraps naturally,
    // so the final probe (k = Requesters) lands on last_q itself.
    always_comb begin
        logic [IdWidth-1:0] idx;
        pick_id    = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= Requesters; k++) begin
            idx = last_q + IdWidth'(k);
            if (!pick_valid && req[idx]) begin
                pick_id    = idx;
                pick_valid = 1'b1;
            end
        end
    end

    assign req_granted = req[grant_q];
    assign burst_open  = (burst_q < BurstWidth'(MaxBurst));
    assign push        = (state_q == StSend) && req_granted && !tx_busy;

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                // A withdrawn request ends the grant; a busy packager just holds us here and
                // other requesters cannot preempt.
                if (!req_granted) begin
                    state_d = StIdle;
                end else if (!tx_busy) begin
                    state_d = StPush;
                end
            end
            StPush: begin
                if (req_granted && burst_open) begin
                    state_d = StSend;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: grant bookkeeping and registered outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        grant_d   = grant_q;
        last_d    = last_q;
        burst_d   = burst_q;
        ack_d     = '0;
        tx_ce_d   = 1'b0;
        tx_data_d = tx_data_q;
        active_d  = (state_d != StIdle);

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_id;
                    burst_d = '0;
                end
            end
            StSend: begin
                if (!req_granted) begin
                    last_d = grant_q;
                end else if (!tx_busy) begin
                    burst_d = burst_q + BurstWidth'(1);
                end
            end
            StPush: begin
                if (!(req_granted && burst_open)) begin
                    last_d = grant_q;
                end
            end
            default: begin
                last_d = grant_q;
            end
        endcase

        // The packet is captured in the same cycle the push is decided, so the packager sees
        // exactly the data presented alongside the request in SEND.
        if (push) begin
            tx_ce_d        = 1'b1;
            ack_d[grant_q] = 1'b1;
            tx_data_d      = data_arr[grant_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q   <= '0;
            last_q    <= IdWidth'(Requesters - 1);
            burst_q   <= '0;
            ack_q     <= '0;
            tx_ce_q   <= 1'b0;
            tx_data_q <= '0;
            active_q  <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            ack_q     <= ack_d;
            tx_ce_q   <= tx_ce_d;
            tx_data_q <= tx_data_d;
            active_q  <= active_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign active   = active_q;
    assign tx_ce    = tx_ce_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_serial_tx_arbiter
//
// Two arbiters (MaxBurst = 4 and MaxBurst = 1) run side by side, each with its own stimulus and
// its own transaction-level reference model. Directed scenarios come first, then a long
// randomized run with protocol-following requesters, random busy and occasional resets.
// ---------------------------------------------------------------------------------------------
module tb_serial_tx_arbiter;

    localparam int IdW = 2;
    localparam int PW  = 32;
    localparam int NR  = 4;
    localparam int NI  = 2;

    logic clk = 1'b0;
    logic rst;

    logic [NR-1:0]    req      [NI];
    logic [NR*PW-1:0] data     [NI];
    logic             tx_busy  [NI];
    logic [NR-1:0]    ack      [NI];
    logic [IdW-1:0]   grant_id [NI];
    logic             active   [NI];
    logic             tx_ce    [NI];
    logic [PW-1:0]    tx_data  [NI];

    always #5 clk = ~clk;

    serial_tx_arbiter #(
        .IdWidth    (IdW),
        .PacketWidth(PW),
        .MaxBurst   (4)
    ) u_dut_b4 (
        .clk     (clk),
        .rst     (rst),
        .req     (req[0]),
        .data    (data[0]),
        .ack     (ack[0]),
        .grant_id(grant_id[0]),
        .active  (active[0]),
        .tx_ce   (tx_ce[0]),
        .tx_data (tx_data[0]),
        .tx_busy (tx_busy[0])
    );

    serial_tx_arbiter #(
        .IdWidth    (IdW),
        .PacketWidth(PW),
        .MaxBurst   (1)
    ) u_dut_b1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req[1]),
        .data    (data[1]),
        .ack     (ack[1]),
        .grant_id(grant_id[1]),
        .active  (active[1]),
        .tx_ce   (tx_ce[1]),
        .tx_data (tx_data[1]),
        .tx_busy (tx_busy[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: who owns the packager, how many packets it has sent in this grant,
    // whether its packet is on the wire right now, and who was served last.
    int        max_burst    [NI] = '{4, 1};
    int        m_owner      [NI];
    int        m_last       [NI];
    int        m_sent       [NI];
    int        m_grant      [NI];
    bit        m_pushing    [NI];
    bit        exp_ce       [NI];
    bit        exp_active   [NI];
    bit        exp_data_chk [NI];
    logic [NR-1:0] exp_ack  [NI];
    logic [PW-1:0] exp_data [NI];

    int want [NI][NR];

    int log_id0[$];
    int log_cyc0[$];
    int log_id1[$];
    int log_cyc1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int onehot_id(input logic [NR-1:0] a);
        for (int i = 0; i < NR; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int j);
        bit found;
        int idx;
        exp_ce[j]       = 1'b0;
        exp_ack[j]      = '0;
        exp_data_chk[j] = 1'b0;
        if (!rst) begin
            m_owner[j]      = -1;
            m_last[j]       = NR - 1;
            m_sent[j]       = 0;
            m_pushing[j]    = 1'b0;
            m_grant[j]      = 0;
            exp_data[j]     = '0;
            exp_data_chk[j] = 1'b1;
        end else if (m_owner[j] < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last[j] + k) % NR;
                if (!found && req[j][idx]) begin
                    found      = 1'b1;
                    m_owner[j] = idx;
                end
            end
            if (found) begin
                m_grant[j] = m_owner[j];
                m_sent[j]  = 0;
            end
        end else if (m_pushing[j]) begin
            m_pushing[j] = 1'b0;
            if (!(req[j][m_owner[j]] && m_sent[j] < max_burst[j])) begin
                m_last[j]  = m_owner[j];
                m_owner[j] = -1;
            end
        end else begin
            if (!req[j][m_owner[j]]) begin
                m_last[j]  = m_owner[j];
                m_owner[j] = -1;
            end else if (!tx_busy[j]) begin
                exp_ce[j]             = 1'b1;
                exp_ack[j][m_owner[j]] = 1'b1;
                exp_data[j]           = data[j][m_owner[j]*PW +: PW];
                exp_data_chk[j]       = 1'b1;
                m_sent[j]++;
                m_pushing[j]          = 1'b1;
            end
        end
        exp_active[j] = (m_owner[j] >= 0);
    endtask

    task automatic compare_inst(input int j);
        check($sformatf("ack[%0d]", j), 32'(ack[j]), 32'(exp_ack[j]));
        check($sformatf("tx_ce[%0d]", j), 32'(tx_ce[j]), 32'(exp_ce[j]));
        check($sformatf("active[%0d]", j), 32'(active[j]), 32'(exp_active[j]));
        check($sformatf("grant_id[%0d]", j), 32'(grant_id[j]), 32'(m_grant[j]));
        if (exp_data_chk[j]) begin
            check($sformatf("tx_data[%0d]", j), tx_data[j], exp_data[j]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int j = 0; j < NI; j++) model_step(j);
        @(negedge clk);
        cyc++;
        for (int j = 0; j < NI; j++) compare_inst(j);
        if (tx_ce[0]) begin
            log_id0.push_back(onehot_id(ack[0]));
            log_cyc0.push_back(cyc);
        end
        if (tx_ce[1]) begin
            log_id1.push_back(onehot_id(ack[1]));
            log_cyc1.push_back(cyc);
        end
    endtask

    task automatic set_req(input logic [NR-1:0] r);
        for (int j = 0; j < NI; j++) req[j] = r;
    endtask

    task automatic set_busy(input logic b);
        for (int j = 0; j < NI; j++) tx_busy[j] = b;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_req('0);
        set_busy(1'b0);
        cycle();
        rst = 1'b1;
        cyc = 0;
        log_id0.delete();
        log_cyc0.delete();
        log_id1.delete();
        log_cyc1.delete();
    endtask

    // Requesters hold req while they have packets left, consume one per ack and then present a
    // fresh packet; now and then one gives up mid-request.
    task automatic rand_stim();
        for (int j = 0; j < NI; j++) begin
            for (int i = 0; i < NR; i++) begin
                if (ack[j][i]) begin
                    if (want[j][i] > 0) want[j][i]--;
                    data[j][i*PW +: PW] = $urandom();
                end
                if (want[j][i] == 0 && $urandom_range(0, 7) == 0) begin
                    want[j][i] = $urandom_range(1, 9);
                end else if (want[j][i] > 0 && $urandom_range(0, 79) == 0) begin
                    want[j][i] = 0;
                end
                req[j][i] = (want[j][i] > 0);
            end
            tx_busy[j] = ($urandom_range(0, 3) == 0);
        end
        rst = ($urandom_range(0, 399) != 0);
    endtask

    initial begin
        int stall_ce;
        int stall_act;

        rst = 1'b0;
        for (int j = 0; j < NI; j++) begin
            req[j]     = '0;
            tx_busy[j] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                data[j][i*PW +: PW] = $urandom();
                want[j][i]          = 0;
            end
        end

        // Reset held with every requester asking.
        set_req(4'b1111);
        repeat (3) cycle();
        rst = 1'b1;
        cyc = 0;
        log_id0.delete();
        log_cyc0.delete();
        log_id1.delete();
        log_cyc1.delete();

        // Round robin with everybody requesting.
        repeat (16) cycle();
        check("b4_first_push_seen", 32'(log_cyc0.size() > 0), 32'd1);
        if (log_cyc0.size() > 0) begin
            check("b4_first_push_cyc", 32'(log_cyc0[0]), 32'd2);
            check("b4_first_push_id", 32'(log_id0[0]), 32'd0);
        end
        check("rr_push_count", 32'(log_id1.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < log_id1.size()) begin
                check($sformatf("rr_id_%0d", k), 32'(log_id1[k]), 32'(k % NR));
                check($sformatf("rr_cyc_%0d", k), 32'(log_cyc1[k]), 32'(2 + 3 * k));
            end
        end

        // Burst cap: requester 2 alone, requester 3 joins during the first burst.
        do_reset();
        set_req(4'b0100);
        repeat (2) cycle();
        set_req(4'b1100);
        repeat (28) cycle();
        check("burst_push_count_ge5", 32'(log_id0.size() >= 5), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < log_id0.size()) begin
                check($sformatf("burst_id_%0d", k), 32'(log_id0[k]), 32'd2);
                check($sformatf("burst_cyc_%0d", k), 32'(log_cyc0[k]), 32'(2 + 2 * k));
            end
        end
        if (log_id0.size() >= 5) begin
            check("burst_next_id", 32'(log_id0[4]), 32'd3);
            check("burst_next_cyc", 32'(log_cyc0[4]), 32'd11);
        end

        // Stall: packager busy for 10 cycles while requester 2 is granted.
        do_reset();
        for (int j = 0; j < NI; j++) data[j][2*PW +: PW] = 32'hDEADBEEF;
        set_req(4'b0100);
        set_busy(1'b1);
        cycle();
        stall_ce  = 0;
        stall_act = 0;
        repeat (10) begin
            cycle();
            stall_ce  += int'(tx_ce[0]);
            stall_act += int'(active[0]);
        end
        check("stall_no_push", 32'(stall_ce), 32'd0);
        check("stall_active", 32'(stall_act), 32'd10);
        set_busy(1'b0);
        cycle();
        check("stall_release_ce", 32'(tx_ce[0]), 32'd1);
        check("stall_release_data", tx_data[0], 32'hDEADBEEF);
        set_req('0);
        repeat (4) cycle();

        // Withdraw: requester 1 drops its request while in SEND.
        do_reset();
        set_req(4'b0110);
        cycle();
        check("wd_grant1", 32'(grant_id[0]), 32'd1);
        set_req(4'b0100);
        cycle();
        check("wd_no_ce", 32'(tx_ce[0]), 32'd0);
        check("wd_no_ack", 32'(ack[0]), 32'd0);
        check("wd_idle", 32'(active[0]), 32'd0);
        cycle();
        check("wd_next_grant", 32'(grant_id[0]), 32'd2);
        cycle();
        check("wd_next_ack", 32'(ack[0]), 32'b0100);
        set_req('0);
        repeat (3) cycle();

        // Reset arriving in the SEND cycle with the packager ready.
        do_reset();
        set_req(4'b1000);
        cycle();
        check("rmid_grant3", 32'(grant_id[0]), 32'd3);
        rst = 1'b0;
        cycle();
        check("rmid_no_ce", 32'(tx_ce[0]), 32'd0);
        check("rmid_no_ack", 32'(ack[0]), 32'd0);
        rst = 1'b1;
        set_req(4'b1001);
        cycle();
        check("rmid_restart_grant", 32'(grant_id[0]), 32'd0);
        set_req('0);
        repeat (4) cycle();

        // Randomized traffic.
        repeat (3000) begin
            rand_stim();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
